// File: rtl/memory_if.sv
// Data-memory stage bus: stage inputs driven by the pipeline, registered load
// result and pipeline sideband returned to writeback.
interface memory_if #(
  parameter int XLEN = 32
);
  logic            en;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] write_data;
  logic            write;
  logic [1:0]      size;
  logic            load_unsigned;
  logic [XLEN-1:0] read_data;
  logic            en_wb;
  logic            en_wb_out;
  logic [4:0]      reg_write;
  logic [4:0]      reg_write_out;

  modport master (
    output en, addr, write_data, write, size, load_unsigned, en_wb, reg_write,
    input  read_data, en_wb_out, reg_write_out
  );

  modport slave (
    input  en, addr, write_data, write, size, load_unsigned, en_wb, reg_write,
    output read_data, en_wb_out, reg_write_out
  );
endinterface

// File: rtl/memory.sv
// Byte-addressed little-endian data memory stage with registered load result
// and one-cycle delay of the writeback sideband (en_wb, reg_write).
`ifndef MEMORY_SIZE_DEFINES
`define MEMORY_SIZE_DEFINES
`define SIZE_8  2'b00
`define SIZE_16 2'b01
`define SIZE_32 2'b10
`endif

module memory #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4096
) (
  input logic      clk,
  input logic      rst,
  memory_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  // Timing contract: there is no valid/ready pair; en qualifies every input
  // for the coming rising edge, and outputs change only on such edges (or
  // asynchronously to zero while rst is low).

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   byte_addr [4];
  logic [7:0]      rd_byte [4];
  logic [31:0]     load_word;
  logic            sext;

  logic [XLEN-1:0] read_data_d, read_data_q;
  logic            en_wb_out_d, en_wb_out_q;
  logic [4:0]      reg_write_out_d, reg_write_out_q;

  // Only the low AW address bits select a byte; the rest wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[XLEN-1:AW];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byte_addr[i] = bus.addr[AW-1:0] + AW'(i);
      rd_byte[i]   = mem[byte_addr[i]];
    end
  end

  always_comb begin
    load_word = 32'h0;
    sext      = 1'b0;
    case (bus.size)
      `SIZE_8: begin
        sext      = rd_byte[0][7] & ~bus.load_unsigned;
        load_word = {{24{sext}}, rd_byte[0]};
      end
      `SIZE_16: begin
        sext      = rd_byte[1][7] & ~bus.load_unsigned;
        load_word = {{16{sext}}, rd_byte[1], rd_byte[0]};
      end
      default: load_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
    endcase
  end

  always_comb begin
    read_data_d     = read_data_q;
    en_wb_out_d     = en_wb_out_q;
    reg_write_out_d = reg_write_out_q;
    if (bus.en) begin
      read_data_d     = bus.write ? '0 : XLEN'(load_word);
      en_wb_out_d     = bus.en_wb;
      reg_write_out_d = bus.reg_write;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.en && bus.write) begin
      mem[byte_addr[0]] <= bus.write_data[7:0];
      if (bus.size != `SIZE_8) begin
        mem[byte_addr[1]] <= bus.write_data[15:8];
      end
      if (bus.size[1]) begin
        mem[byte_addr[2]] <= bus.write_data[23:16];
        mem[byte_addr[3]] <= bus.write_data[31:24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q     <= '0;
      en_wb_out_q     <= 1'b0;
      reg_write_out_q <= 5'd0;
    end else begin
      read_data_q     <= read_data_d;
      en_wb_out_q     <= en_wb_out_d;
      reg_write_out_q <= reg_write_out_d;
    end
  end

  assign bus.read_data     = read_data_q;
  assign bus.en_wb_out     = en_wb_out_q;
  assign bus.reg_write_out = reg_write_out_q;
endmodule

// File: tb/tb_memory.sv
// Bench for memory: byte-array reference model checked every cycle, plus
// directed vectors with hand-computed expected values.
module tb_memory;
  localparam int XLEN  = 32;
  localparam int DEPTH = 256;
  localparam logic [1:0] S8 = 2'b00, S16 = 2'b01, S32 = 2'b10, S3 = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic check_en = 1'b0;

  memory_if #(.XLEN(XLEN)) bus ();

  memory #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  m_mem [DEPTH];
  bit          m_valid [DEPTH];
  logic [31:0] exp_rd = 32'h0;
  logic        exp_rd_known = 1'b1;
  logic        exp_wb = 1'b0;
  logic [4:0]  exp_rw = 5'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_rd = 32'h0; exp_rd_known = 1'b1; exp_wb = 1'b0; exp_rw = 5'd0;
    end else if (bus.en) begin
      int nb;
      logic [31:0] val;
      logic [31:0] ones;
      logic [31:0] ia;
      int idx;
      nb   = (bus.size == S8) ? 1 : (bus.size == S16) ? 2 : 4;
      ones = '1;
      exp_wb = bus.en_wb;
      exp_rw = bus.reg_write;
      if (bus.write) begin
        for (int i = 0; i < nb; i++) begin
          ia  = bus.addr + 32'(i);
          idx = int'(ia % DEPTH);
          m_mem[idx]   = 8'(bus.write_data >> (8 * i));
          m_valid[idx] = 1'b1;
        end
        exp_rd = 32'h0;
        exp_rd_known = 1'b1;
      end else begin
        val = 32'h0;
        exp_rd_known = 1'b1;
        for (int i = 0; i < nb; i++) begin
          ia  = bus.addr + 32'(i);
          idx = int'(ia % DEPTH);
          val = val | (32'(m_mem[idx]) << (8 * i));
          if (!m_valid[idx]) exp_rd_known = 1'b0;
        end
        if (!bus.load_unsigned && nb < 4 && val[8*nb-1]) val = val | (ones << (8 * nb));
        exp_rd = val;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      if (exp_rd_known) check("model_read_data", bus.read_data, exp_rd);
      check("model_en_wb_out", 32'(bus.en_wb_out), 32'(exp_wb));
      check("model_reg_write_out", 32'(bus.reg_write_out), 32'(exp_rw));
    end
  end

  // ---------------- driver ----------------
  task automatic op(input logic e, input logic w, input logic [1:0] sz, input logic lu,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic ewb, input logic [4:0] rw);
    bus.en = e; bus.write = w; bus.size = sz; bus.load_unsigned = lu;
    bus.addr = a; bus.write_data = wd; bus.en_wb = ewb; bus.reg_write = rw;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        lu;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11] = '{
    '{1'b1, S32, 1'b0, 32'd32, 32'h0000_0000, 1'b0, 32'h0},
    '{1'b1, S16, 1'b0, 32'd32, 32'h1234_BEEF, 1'b0, 32'h0},
    '{1'b0, S16, 1'b0, 32'd32, 32'h0,         1'b1, 32'hFFFF_BEEF},
    '{1'b0, S8,  1'b1, 32'd33, 32'h0,         1'b1, 32'h0000_00BE},
    '{1'b1, S8,  1'b0, 32'd34, 32'hFFFF_FF7F, 1'b0, 32'h0},
    '{1'b0, S3,  1'b1, 32'd32, 32'h0,         1'b1, 32'h007F_BEEF},
    '{1'b0, S8,  1'b0, 32'd34, 32'h0,         1'b1, 32'h0000_007F},
    '{1'b1, S32, 1'b0, 32'd37, 32'hA5A5_A5A5, 1'b0, 32'h0},
    '{1'b0, S16, 1'b1, 32'd38, 32'h0,         1'b1, 32'h0000_A5A5},
    '{1'b0, S32, 1'b0, 32'd37, 32'h0,         1'b1, 32'hA5A5_A5A5},
    '{1'b0, S8,  1'b0, 32'd40, 32'h0,         1'b1, 32'hFFFF_FFA5}
  };

  initial begin
    bus.en = 1'b0; bus.write = 1'b0; bus.size = S32; bus.load_unsigned = 1'b0;
    bus.addr = '0; bus.write_data = '0; bus.en_wb = 1'b0; bus.reg_write = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_read_data", bus.read_data, 32'h0);
    check("reset_en_wb_out", 32'(bus.en_wb_out), 32'h0);
    check("reset_reg_write_out", 32'(bus.reg_write_out), 32'h0);
    rst = 1'b1;
    check_en = 1'b1;

    // Overlay of word, half, byte stores
    op(1, 1, S32, 0, 32'd0, 32'hFFFF_FFFF, 1, 5'd3);
    op(1, 1, S16, 0, 32'd0, 32'h0000_AAAA, 0, 5'd4);
    op(1, 1, S8,  0, 32'd0, 32'h0000_0055, 1, 5'd6);
    op(1, 0, S32, 0, 32'd0, 32'h0,         1, 5'd1);
    check("overlay_word", bus.read_data, 32'hFFFF_AA55);

    // Halfword extension
    op(1, 1, S32, 0, 32'd8, 32'h0000_8000, 0, 5'd0);
    op(1, 0, S16, 1, 32'd8, 32'h0, 0, 5'd0);
    check("half_unsigned", bus.read_data, 32'h0000_8000);
    op(1, 0, S16, 0, 32'd8, 32'h0, 0, 5'd0);
    check("half_signed", bus.read_data, 32'hFFFF_8000);

    // Byte extension
    op(1, 1, S32, 0, 32'd12, 32'h0000_0080, 0, 5'd0);
    op(1, 0, S8, 1, 32'd12, 32'h0, 0, 5'd0);
    check("byte_unsigned", bus.read_data, 32'h0000_0080);
    op(1, 0, S8, 0, 32'd12, 32'h0, 0, 5'd0);
    check("byte_signed", bus.read_data, 32'hFFFF_FF80);

    // Pipeline sideband and enable hold
    op(1, 0, S32, 0, 32'd12, 32'h0, 1, 5'd5);
    check("pipe_en_wb_out", 32'(bus.en_wb_out), 32'h1);
    check("pipe_reg_write_out", 32'(bus.reg_write_out), 32'd5);
    check("pipe_read_data", bus.read_data, 32'h0000_0080);
    op(0, 1, S32, 0, 32'd8, 32'hDEAD_BEEF, 0, 5'd9);
    check("hold_read_data", bus.read_data, 32'h0000_0080);
    check("hold_en_wb_out", 32'(bus.en_wb_out), 32'h1);
    check("hold_reg_write_out", 32'(bus.reg_write_out), 32'd5);
    op(1, 0, S32, 0, 32'd8, 32'h0, 0, 5'd2);
    check("hold_no_store", bus.read_data, 32'h0000_8000);

    // Asynchronous reset between edges; storage survives
    op(1, 0, S32, 0, 32'd0, 32'h0, 1, 5'd7);
    check("pre_reset_read", bus.read_data, 32'hFFFF_AA55);
    #2 rst = 1'b0;
    #1;
    check("midreset_read_data", bus.read_data, 32'h0);
    check("midreset_en_wb_out", 32'(bus.en_wb_out), 32'h0);
    check("midreset_reg_write_out", 32'(bus.reg_write_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    op(1, 0, S32, 0, 32'd0, 32'h0, 1, 5'd8);
    check("post_reset_read", bus.read_data, 32'hFFFF_AA55);

    // Unaligned store wrapping past the top of storage
    op(1, 1, S32, 0, 32'(DEPTH - 2), 32'h1122_3344, 0, 5'd0);
    op(1, 0, S8, 1, 32'd0, 32'h0, 0, 5'd0);
    check("wrap_byte0", bus.read_data, 32'h0000_0022);
    op(1, 0, S16, 1, 32'(DEPTH - 1), 32'h0, 0, 5'd0);
    check("wrap_half", bus.read_data, 32'h0000_2233);
    op(1, 0, S32, 0, 32'(DEPTH - 2), 32'h0, 1, 5'd31);
    check("wrap_word", bus.read_data, 32'h1122_3344);
    op(1, 0, S32, 0, 32'(DEPTH + 12), 32'h0, 0, 5'd0);
    check("alias_high_addr", bus.read_data, 32'h0000_0080);

    // Mixed directed vectors
    foreach (tbl[i]) begin
      op(1, tbl[i].w, tbl[i].sz, tbl[i].lu, tbl[i].a, tbl[i].wd, 1'(i % 2), 5'(i + 10));
      if (tbl[i].chk) check($sformatf("vec%0d", i), bus.read_data, tbl[i].exp);
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter DEPTH, default 4096, storage size in bytes (power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  stage enable; when low, no write and all output registers hold.
REQ-006 SHALL have port addr  input  XLEN  byte address, from the ALU result.
REQ-007 SHALL have port write_data  input  XLEN  store data, right-justified.
REQ-008 SHALL have port write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port size  input  2  access size: 2'b00 SIZE_8, 2'b01 SIZE_16, 2'b10 SIZE_32, 2'b11 treated as SIZE_32.
REQ-010 SHALL have port load_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-011 SHALL have port read_data  output  XLEN  registered load result.
REQ-012 SHALL have port en_wb  input  1  writeback enable from previous stage.
REQ-013 SHALL have port en_wb_out  output  1  en_wb delayed one cycle.
REQ-014 SHALL have port reg_write  input  5  destination register index.
REQ-015 SHALL have port reg_write_out  output  5  reg_write delayed one cycle.
REQ-016 SHALL provide SIZE_8, SIZE_16 and SIZE_32 as shared defines carrying the encodings above.

Function
REQ-017 SHALL store DEPTH bytes, byte-addressed and little-endian; byte index = addr mod DEPTH.
REQ-018 SHALL, on a rising edge with en=1 and write=1, write the low 1/2/4 bytes of write_data (per size) to addr, addr+1, ...; other bytes unchanged.
REQ-019 SHALL support unaligned accesses byte-wise; byte addresses wrap modulo DEPTH.
REQ-020 SHALL, on a rising edge with en=1 and write=0, register into read_data the 1/2/4 bytes at addr (per size); result visible one cycle after addr is presented.
REQ-021 SHALL zero-extend SIZE_8/SIZE_16 loads when load_unsigned=1 and sign-extend from bit 7/15 when load_unsigned=0; SIZE_32 ignores load_unsigned.
REQ-022 SHALL, on a store cycle (en=1, write=1), load read_data with 0.
REQ-023 SHALL, on a rising edge with en=1, register en_wb into en_wb_out and reg_write into reg_write_out, regardless of write.
REQ-024 SHALL have read-before-write semantics; a load never observes a store in the same edge (write and load are exclusive via write).
REQ-025 SHALL ignore write_data on loads (may be high-Z).
REQ-026 SHALL, with en=0, perform no store and hold read_data, en_wb_out, reg_write_out.

Reset
REQ-027 SHALL, while rst=0 (asynchronous), force read_data=0, en_wb_out=0, reg_write_out=0.
REQ-028 SHALL NOT clear storage contents on reset; contents are undefined until written.
REQ-029 SHALL resume normal operation on the first rising edge after rst returns to 1.

Verification
REQ-030 Overlay: store SIZE_32 0xFFFFFFFF @0, SIZE_16 0x0000AAAA @0, SIZE_8 0x55 @0; load SIZE_32 @0 -> read_data=0xFFFFAA55 next edge.
REQ-031 Half extension: store SIZE_32 0x00008000 @8; load SIZE_16 @8 unsigned -> 0x00008000; signed -> 0xFFFF8000.
REQ-032 Byte extension: store SIZE_32 0x00000080 @12; load SIZE_8 @12 unsigned -> 0x00000080; signed -> 0xFFFFFF80.
REQ-033 Unaligned/wrap: store SIZE_32 0x11223344 @DEPTH-2; load SIZE_8 @0 -> 0x22; SIZE_16 @DEPTH-1 unsigned -> 0x00002233.
REQ-034 Pipeline/enable: en_wb=1, reg_write=5 with en=1 -> en_wb_out=1, reg_write_out=5 after one edge; en=0 with store -> memory and outputs unchanged.
REQ-035 Reset mid-operation: assert rst=0 between edges -> read_data, en_wb_out, reg_write_out =0 immediately; earlier stored data still readable after release.
